matrix_power_iter: RTL

- Iterative fixed-point matrix squarer; sits directly upstream of the convergence checker.
- Loads an N_STOCKS x N_STOCKS signed matrix and repeatedly computes A <= A*A on a single shared MAC.
- Presents each result on matrix_out, which drives the checker combinationally, and samples its conv flag.
- Stops on convergence or after MAX_ITER squarings.

---
 rtl/matrix_power_iter_pkg.sv | 36 +++
 rtl/matrix_power_iter_fp_mac.sv | 36 +++
 rtl/matrix_power_iter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/matrix_power_iter_pkg.sv
// Shared types and helpers for the iterative fixed-point matrix squarer.
// The convergence checker reuses matrix_t, so the defaults here must track the top-level parameters.
package matrix_power_iter_pkg;

  localparam int DEF_N_STOCKS = 2;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_FRAC     = 10;
  localparam int ONE_FP       = 1 << DEF_FRAC;

  typedef logic signed [DEF_WIDTH-1:0] elem_t;
  typedef elem_t matrix_t [DEF_N_STOCKS][DEF_N_STOCKS];

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    UPDATE,
    CHECK,
    DONE
  } state_e;

  // Arithmetic shift (floor) followed by a clamp to a signed width-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int frac,
                                                   input int width);
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    shifted = value >>> frac;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/matrix_power_iter_fp_mac.sv
// Signed multiply-accumulate with clear-on-first and a saturating fixed-point output stage.
module fp_mac
  import matrix_power_iter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 10,
  parameter int ACC_W = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    first_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] result_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] product;

  assign product  = ACC_W'(a_i) * ACC_W'(b_i);
  assign acc_d    = (first_i ? '0 : acc_q) + product;
  // The result reflects the sum including this cycle's product, so the final
  // term of a dot product never has to wait for the register.
  assign result_o = WIDTH'(sat_shift(64'(acc_d), FRAC, WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_power_iter.sv
// Repeatedly squares a fixed-point matrix on one shared MAC until the external
// checker flags convergence or MAX_ITER squarings have been done.
module matrix_power_iter
  import matrix_power_iter_pkg::*;
#(
  parameter  int N_STOCKS = DEF_N_STOCKS,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int FRAC     = DEF_FRAC,
  parameter  int MAX_ITER = 16,
  localparam int IW       = $clog2(MAX_ITER + 1),
  localparam int IDX_W    = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] matrix_in  [N_STOCKS][N_STOCKS],
  input  logic                    conv,
  output logic signed [WIDTH-1:0] matrix_out [N_STOCKS][N_STOCKS],
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [IW-1:0]           iter_count
);

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] aMat_q   [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] bMat_q   [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] outMat_q [N_STOCKS][N_STOCKS];
  logic [IDX_W-1:0]        rowIdx_q, colIdx_q, kIdx_q;
  logic [IW-1:0]           iter_q;
  logic                    conv_q;

  logic                    lastK, lastCol, lastRow;
  logic signed [WIDTH-1:0] macResult;

  assign lastK   = (kIdx_q   == IDX_W'(N_STOCKS - 1));
  assign lastCol = (colIdx_q == IDX_W'(N_STOCKS - 1));
  assign lastRow = (rowIdx_q == IDX_W'(N_STOCKS - 1));

  fp_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (2 * WIDTH + $clog2(N_STOCKS))
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == MUL),
    .first_i  (kIdx_q == '0),
    .a_i      (aMat_q[rowIdx_q][kIdx_q]),
    .b_i      (aMat_q[kIdx_q][colIdx_q]),
    .result_o (macResult)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MUL;
      MUL:     if (lastK && lastCol && lastRow) state_d = UPDATE;
      UPDATE:  state_d = CHECK;
      CHECK: begin
        if (conv || (iter_q == IW'(MAX_ITER))) state_d = DONE;
        else                                    state_d = MUL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_STOCKS; r++) begin
        for (int c = 0; c < N_STOCKS; c++) begin
          aMat_q[r][c]   <= '0;
          bMat_q[r][c]   <= '0;
          outMat_q[r][c] <= '0;
        end
      end
      rowIdx_q <= '0;
      colIdx_q <= '0;
      kIdx_q   <= '0;
      iter_q   <= '0;
      conv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            aMat_q   <= matrix_in;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            rowIdx_q <= '0;
            colIdx_q <= '0;
            kIdx_q   <= '0;
          end
        end
        MUL: begin
          // k is innermost; each (i,j) result lands in B on its final k.
          if (lastK) begin
            bMat_q[rowIdx_q][colIdx_q] <= macResult;
            kIdx_q <= '0;
            if (lastCol) begin
              colIdx_q <= '0;
              rowIdx_q <= lastRow ? '0 : rowIdx_q + IDX_W'(1);
            end else begin
              colIdx_q <= colIdx_q + IDX_W'(1);
            end
          end else begin
            kIdx_q <= kIdx_q + IDX_W'(1);
          end
        end
        UPDATE: begin
          aMat_q   <= bMat_q;
          outMat_q <= bMat_q;
          iter_q   <= iter_q + IW'(1);
        end
        CHECK: begin
          if (conv) conv_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign matrix_out = outMat_q;
  assign busy       = (state_q == MUL) || (state_q == UPDATE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule
